// File: rtl/reg_write_seq_pkg.sv
// Shared defaults and the write-queue record for the register write sequencer.
package reg_write_seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREGS_DEF = 2;
  localparam int DEPTH_DEF = 4;
  localparam int ADDR_W    = 3;
  localparam int BE_W      = 2;

  // Record at the default width; modules with a non-default WIDTH declare the same layout locally.
  typedef struct packed {
    logic [ADDR_W-1:0]    addr;
    logic [WIDTH_DEF-1:0] data;
    logic [BE_W-1:0]      be;
  } wr_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Circular synchronous FIFO with power-of-two depth; pointers wrap naturally.
module sync_fifo
  import reg_write_seq_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone decide which slots are live.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/reg_write_seq.sv
// Queued byte-enabled register writer: requests are buffered, then applied one per edge.
module reg_write_seq
  import reg_write_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [2:0]             wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic [1:0]             wr_be,
  output logic [NREGS*WIDTH-1:0] r_out,
  output logic                   busy,
  output logic                   addr_err
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
    logic [BE_W-1:0]   be;
  } entry_t;

  localparam int EW = $bits(entry_t);
  localparam logic [ADDR_W:0] NREGS_LIM = (ADDR_W+1)'(NREGS);

  // Handshake: a request transfers on a rising edge where wr_valid and wr_ready are
  // both 1; wr_ready is a function of registered state only, never of wr_valid.
  entry_t           in_entry;
  entry_t           head;
  logic [EW-1:0]    head_bits;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             ready_en;
  logic             addr_ok;
  logic [WIDTH-1:0] mask;
  logic [WIDTH-1:0] regs [NREGS];

  assign in_entry = '{addr: wr_addr, data: wr_data, be: wr_be};
  assign head     = entry_t'(head_bits);
  assign wr_ready = ready_en & ~full;
  assign push     = wr_valid & wr_ready;
  assign pop      = ~empty;
  assign busy     = ~empty;
  assign addr_ok  = ({1'b0, head.addr} < NREGS_LIM);

  sync_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (EW'(in_entry)),
    .dout  (head_bits),
    .full  (full),
    .empty (empty)
  );

  // Bits above 15 have no enable and always keep their value.
  always_comb begin
    mask = '0;
    for (int b = 0; b < WIDTH; b++) begin
      mask[b] = (b < 16) && head.be[b[3]];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready_en <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      addr_err <= pop & ~addr_ok;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        regs[i] <= '0;
      end else if (pop && head.addr == ADDR_W'(i)) begin
        regs[i] <= (regs[i] & ~mask) | (head.data & mask);
      end
    end
    assign r_out[WIDTH*(NREGS-1-i) +: WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_reg_write_seq.sv
// Bench for reg_write_seq: directed table, burst, reset-with-pending and random traffic vs a queue model.
module tb_reg_write_seq;

  localparam int WIDTH = 16;
  localparam int NREGS = 2;
  localparam int DEPTH = 4;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic                   wr_valid = 1'b0;
  logic [2:0]             wr_addr = '0;
  logic [WIDTH-1:0]       wr_data = '0;
  logic [1:0]             wr_be = '0;
  logic                   wr_ready;
  logic [NREGS*WIDTH-1:0] r_out;
  logic                   busy;
  logic                   addr_err;

  int checks = 0;
  int errors = 0;

  // Model: pending requests as {addr, data, be}, register image, expected error pulse.
  logic [20:0] exp_q[$];
  logic [15:0] model_regs [NREGS];
  logic        model_err = 1'b0;
  logic        model_rdy = 1'b0;

  typedef struct {
    logic        v;
    logic [2:0]  a;
    logic [15:0] d;
    logic [1:0]  b;
    logic [31:0] rout;
    logic        bsy;
    logic        err;
  } vec_t;

  vec_t        vecs [11];
  logic [15:0] last_w [NREGS];

  always #5 clock = ~clock;

  reg_write_seq #(.WIDTH(WIDTH), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .r_out    (r_out),
    .busy     (busy),
    .addr_err (addr_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NREGS*WIDTH-1:0] model_rout();
    logic [NREGS*WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < NREGS; i++) r[WIDTH*(NREGS-1-i) +: WIDTH] = model_regs[i];
    return r;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    for (int i = 0; i < NREGS; i++) model_regs[i] = '0;
    model_err = 1'b0;
    model_rdy = 1'b0;
  endtask

  // One clock: drive at negedge, update model at posedge, compare at next negedge.
  task automatic step(input logic v, input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
    logic        acc;
    logic [20:0] e;
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = b;
    acc = v && model_rdy && (exp_q.size() < DEPTH);
    @(posedge clock);
    model_err = 1'b0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (int'(e[20:18]) < NREGS) begin
        for (int k = 0; k < 2; k++)
          if (e[k]) model_regs[e[20:18]][8*k +: 8] = e[2+8*k +: 8];
      end else begin
        model_err = 1'b1;
      end
    end
    if (acc) exp_q.push_back({a, d, b});
    model_rdy = 1'b1;
    @(negedge clock);
    wr_valid = 1'b0;
    check("r_out", r_out, model_rout());
    check("busy", busy, exp_q.size() > 0);
    check("wr_ready", wr_ready, model_rdy && (exp_q.size() < DEPTH));
    check("addr_err", addr_err, model_err);
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    model_clear();
    check("rst_r_out", r_out, '0);
    check("rst_wr_ready", wr_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    @(posedge clock);
    #1;
    check("rst_hold_ready", wr_ready, 1'b0);
    check("rst_hold_r_out", r_out, '0);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    model_clear();
    vecs[0]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 32'h0000_0000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 3'd0, 16'hA5C3, 2'b11, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 32'hA5C3_0000, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 3'd1, 16'hFFFF, 2'b11, 32'hA5C3_0000, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 3'd1, 16'h1234, 2'b01, 32'hA5C3_FFFF, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 32'hA5C3_FF34, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 3'd5, 16'h0000, 2'b11, 32'hA5C3_FF34, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 3'd0, 16'hBEEF, 2'b10, 32'hA5C3_FF34, 1'b1, 1'b1};
    vecs[8]  = '{1'b0, 3'd0, 16'h0000, 2'b00, 32'hBEC3_FF34, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 3'd0, 16'h1111, 2'b00, 32'hBEC3_FF34, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 3'd0, 16'h0000, 2'b00, 32'hBEC3_FF34, 1'b0, 1'b0};

    repeat (3) @(negedge clock);
    check("init_r_out", r_out, '0);
    check("init_wr_ready", wr_ready, 1'b0);
    check("init_busy", busy, 1'b0);
    check("init_addr_err", addr_err, 1'b0);
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      step(vecs[i].v, vecs[i].a, vecs[i].d, vecs[i].b);
      check($sformatf("tbl%0d_r_out", i), r_out, vecs[i].rout);
      check($sformatf("tbl%0d_busy", i), busy, vecs[i].bsy);
      check($sformatf("tbl%0d_addr_err", i), addr_err, vecs[i].err);
    end

    // Continuous pushes: pointers wrap several times, last write per address wins.
    last_w[0] = 16'hBEC3;
    last_w[1] = 16'hFF34;
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  a;
      logic [15:0] d;
      a = 3'($urandom_range(0, 1));
      d = 16'($urandom);
      step(1'b1, a, d, 2'b11);
      last_w[a] = d;
    end
    step(1'b0, 3'd0, 16'h0, 2'b00);
    step(1'b0, 3'd0, 16'h0, 2'b00);
    check("burst_final", r_out, {last_w[0], last_w[1]});

    // Reset with an accepted entry still pending: it must never land.
    step(1'b1, 3'd0, 16'h7777, 2'b11);
    mid_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'd0, 16'h0, 2'b00);
      check("post_rst_zero", r_out, '0);
    end

    for (int i = 0; i < 300; i++) begin
      logic [2:0] a;
      a = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      step($urandom_range(0, 3) != 0, a, 16'($urandom), 2'($urandom_range(0, 3)));
      if (i == 150) begin
        step(1'b1, 3'd1, 16'hDEAD, 2'b11);
        mid_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
